// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: ALU/branch control codes, RV32I opcodes,
// the registered issue payload and the funct3 -> ALU control helper.
package alu_issue_pkg;

    localparam int unsigned XLEN = 32;

    // ALU control codes (4-bit, common encoding shared with the ALU)
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;
    localparam logic [3:0] B_BNE    = 4'd11;
    localparam logic [3:0] B_BLT    = 4'd12;
    localparam logic [3:0] B_BGE    = 4'd13;
    localparam logic [3:0] B_LTU    = 4'd14;
    localparam logic [3:0] B_GEU    = 4'd15;

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [3:0]      control;
        logic [XLEN-1:0] left;
        logic [XLEN-1:0] right;
        logic            is_branch;
        logic            illegal;
    } alu_issue_t;

    // Payload for reset and for undecodable ops: ADD of zeros
    localparam alu_issue_t ISSUE_NOP = '{
        control:   ALU_ADD,
        left:      '0,
        right:     '0,
        is_branch: 1'b0,
        illegal:   1'b0
    };

    // Register/immediate arithmetic map; alt selects SUB/SRA where funct3 allows it
    function automatic logic [3:0] funct3_to_ctl(input logic [2:0] funct3, input logic alt);
        logic [3:0] ctl;
        case (funct3)
            3'b000:  ctl = alt ? ALU_SUB : ALU_ADD;
            3'b001:  ctl = ALU_SLL;
            3'b010:  ctl = ALU_SLT;
            3'b011:  ctl = ALU_SLTU;
            3'b100:  ctl = ALU_XOR;
            3'b101:  ctl = alt ? ALU_SRA : ALU_SRL;
            3'b110:  ctl = ALU_OR;
            default: ctl = ALU_AND;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// ID -> issue -> EX handshake bundle. The issue block is the slave; the surrounding
// pipeline (ID producer and EX consumer) is the master.
interface alu_issue_if;
    import alu_issue_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [6:0]      in_opcode;
    logic [2:0]      in_funct3;
    logic            in_funct7b5;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic [XLEN-1:0] in_imm;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_control;
    logic [XLEN-1:0] out_left;
    logic [XLEN-1:0] out_right;
    logic            out_is_branch;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_opcode, in_funct3, in_funct7b5,
        input  in_rs1_data, in_rs2_data, in_imm, in_pc, out_ready,
        output in_ready, out_valid, out_control, out_left, out_right,
        output out_is_branch, out_illegal
    );

    modport master (
        output in_valid, in_opcode, in_funct3, in_funct7b5,
        output in_rs1_data, in_rs2_data, in_imm, in_pc, out_ready,
        input  in_ready, out_valid, out_control, out_left, out_right,
        input  out_is_branch, out_illegal
    );

endinterface

// File: rtl/alu_op_decode.sv
// Pure combinational RV32I decode into ALU control code and operand selection.
// Optional feature macro: ALU_ISSUE_ILLEGAL_EN (report undecodable ops on o_issue.illegal).
module alu_op_decode
    import alu_issue_pkg::*;
#(
    parameter logic [XLEN-1:0] PC_STEP = 32'd4
) (
    input  logic [6:0]      i_opcode,
    input  logic [2:0]      i_funct3,
    input  logic            i_funct7b5,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_pc,
    output alu_issue_t      o_issue
);

    alu_issue_t w_issue;

    // Decode opcode/funct3/funct7b5 into control code and operand muxes
    always_comb begin
        w_issue = ISSUE_NOP;
        case (i_opcode)
            OPC_OP: begin
                w_issue.control = funct3_to_ctl(i_funct3, i_funct7b5);
                w_issue.left    = i_rs1_data;
                w_issue.right   = i_rs2_data;
                // funct7 = 0100000 only exists for SUB and SRA
                w_issue.illegal = i_funct7b5 && (i_funct3 != 3'b000) && (i_funct3 != 3'b101);
            end
            OPC_OPIMM: begin
                // bit30 of an immediate is data except for SRAI
                w_issue.control = funct3_to_ctl(i_funct3, i_funct7b5 && (i_funct3 == 3'b101));
                w_issue.left    = i_rs1_data;
                w_issue.right   = i_imm;
            end
            OPC_LUI: begin
                w_issue.control = ALU_LUI;
                w_issue.right   = i_imm;
            end
            OPC_AUIPC: begin
                w_issue.left  = i_pc;
                w_issue.right = i_imm;
            end
            OPC_LOAD, OPC_STORE: begin
                w_issue.left  = i_rs1_data;
                w_issue.right = i_imm;
            end
            OPC_JAL, OPC_JALR: begin
                w_issue.left  = i_pc;
                w_issue.right = PC_STEP;
            end
            OPC_BRANCH: begin
                w_issue.left      = i_rs1_data;
                w_issue.right     = i_rs2_data;
                w_issue.is_branch = 1'b1;
                case (i_funct3)
                    3'b000: w_issue.control = ALU_SUB;
                    3'b001: w_issue.control = B_BNE;
                    3'b100: w_issue.control = B_BLT;
                    3'b101: w_issue.control = B_BGE;
                    3'b110: w_issue.control = B_LTU;
                    3'b111: w_issue.control = B_GEU;
                    default: begin
                        w_issue         = ISSUE_NOP;
                        w_issue.illegal = 1'b1;
                    end
                endcase
            end
            default: w_issue.illegal = 1'b1;
        endcase
`ifdef ALU_ISSUE_ILLEGAL_EN
        // keep decoded illegal flag
`else
        w_issue.illegal = 1'b0;
`endif
    end

    assign o_issue = w_issue;

endmodule

// File: rtl/alu_issue.sv
// Execute-stage issue register: decoded op is registered behind a valid/ready handshake
// with a one-entry skid buffer so in_ready can be a pure register output.
// Optional feature macro: ALU_ISSUE_ILLEGAL_EN (passed through from alu_op_decode).
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter logic [XLEN-1:0] PC_STEP = 32'd4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_flush,
    alu_issue_if.slave  io_bus
);

    alu_issue_t w_dec;
    alu_issue_t r_out;
    alu_issue_t r_skid;
    alu_issue_t w_out_next;
    alu_issue_t w_skid_next;
    logic       r_out_valid;
    logic       r_skid_valid;
    logic       w_out_valid_next;
    logic       w_skid_valid_next;
    logic       w_accept;
    logic       w_advance;

    alu_op_decode #(
        .PC_STEP (PC_STEP)
    ) u_decode (
        .i_opcode   (io_bus.in_opcode),
        .i_funct3   (io_bus.in_funct3),
        .i_funct7b5 (io_bus.in_funct7b5),
        .i_rs1_data (io_bus.in_rs1_data),
        .i_rs2_data (io_bus.in_rs2_data),
        .i_imm      (io_bus.in_imm),
        .i_pc       (io_bus.in_pc),
        .o_issue    (w_dec)
    );

    assign w_accept  = io_bus.in_valid && !r_skid_valid;
    assign w_advance = !r_out_valid || io_bus.out_ready;

    // Next state of output register and skid; flush wins over any accept
    always_comb begin
        w_out_next        = r_out;
        w_out_valid_next  = r_out_valid;
        w_skid_next       = r_skid;
        w_skid_valid_next = r_skid_valid;
        if (i_flush) begin
            w_out_valid_next  = 1'b0;
            w_skid_valid_next = 1'b0;
        end else if (w_advance) begin
            // skid is older than anything on the input, so it drains first
            if (r_skid_valid) begin
                w_out_next        = r_skid;
                w_out_valid_next  = 1'b1;
                w_skid_valid_next = 1'b0;
            end else if (w_accept) begin
                w_out_next       = w_dec;
                w_out_valid_next = 1'b1;
            end else begin
                w_out_valid_next = 1'b0;
            end
        end else if (w_accept) begin
            w_skid_next       = w_dec;
            w_skid_valid_next = 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out        <= ISSUE_NOP;
            r_out_valid  <= 1'b0;
            r_skid       <= ISSUE_NOP;
            r_skid_valid <= 1'b0;
        end else begin
            r_out        <= w_out_next;
            r_out_valid  <= w_out_valid_next;
            r_skid       <= w_skid_next;
            r_skid_valid <= w_skid_valid_next;
        end
    end

    assign io_bus.in_ready      = !r_skid_valid;
    assign io_bus.out_valid     = r_out_valid;
    assign io_bus.out_control   = r_out.control;
    assign io_bus.out_left      = r_out.left;
    assign io_bus.out_right     = r_out.right;
    assign io_bus.out_is_branch = r_out.is_branch;
    assign io_bus.out_illegal   = r_out.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Randomized + directed bench for alu_issue against a queue-based reference model.
module tb_alu_issue;
    import alu_issue_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    alu_issue_if bus ();

    alu_issue #(
        .PC_STEP (32'd4)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_flush (flush),
        .io_bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Ops accepted but not yet handed to EX, oldest first (at most two)
    alu_issue_t exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_arith(input logic [2:0] f3, input logic alt);
        logic [3:0] tbl [8];
        tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        if (alt && f3 == 3'd0) return ALU_SUB;
        if (alt && f3 == 3'd5) return ALU_SRA;
        return tbl[f3];
    endfunction

    function automatic alu_issue_t ref_decode(input logic [6:0] opc, input logic [2:0] f3,
                                              input logic f7, input logic [31:0] rs1,
                                              input logic [31:0] rs2, input logic [31:0] imm,
                                              input logic [31:0] pc);
        alu_issue_t e;
        logic bad;
        e = '0;
        e.control = ALU_ADD;
        bad = 1'b0;
        if (opc == 7'b0110011) begin
            e.control = ref_arith(f3, f7);
            e.left = rs1;
            e.right = rs2;
            bad = f7 && !(f3 == 3'd0 || f3 == 3'd5);
        end else if (opc == 7'b0010011) begin
            e.control = ref_arith(f3, f7 && f3 == 3'd5);
            e.left = rs1;
            e.right = imm;
        end else if (opc == 7'b0110111) begin
            e.control = ALU_LUI;
            e.right = imm;
        end else if (opc == 7'b0010111) begin
            e.left = pc;
            e.right = imm;
        end else if (opc == 7'b0000011 || opc == 7'b0100011) begin
            e.left = rs1;
            e.right = imm;
        end else if (opc == 7'b1101111 || opc == 7'b1100111) begin
            e.left = pc;
            e.right = 32'd4;
        end else if (opc == 7'b1100011) begin
            if (f3 == 3'd2 || f3 == 3'd3) begin
                bad = 1'b1;
            end else begin
                e.left = rs1;
                e.right = rs2;
                e.is_branch = 1'b1;
                case (f3)
                    3'd0:    e.control = ALU_SUB;
                    3'd1:    e.control = B_BNE;
                    3'd4:    e.control = B_BLT;
                    3'd5:    e.control = B_BGE;
                    3'd6:    e.control = B_LTU;
                    default: e.control = B_GEU;
                endcase
            end
        end else begin
            bad = 1'b1;
        end
`ifdef ALU_ISSUE_ILLEGAL_EN
        e.illegal = bad;
`else
        e.illegal = 1'b0;
`endif
        return e;
    endfunction

    task automatic check_outputs();
        check_eq("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_q.size() > 0});
        check_eq("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_q.size() < 2});
        if (exp_q.size() > 0) begin
            check_eq("control", {28'b0, bus.out_control}, {28'b0, exp_q[0].control});
            check_eq("left", bus.out_left, exp_q[0].left);
            check_eq("right", bus.out_right, exp_q[0].right);
            check_eq("is_branch", {31'b0, bus.out_is_branch}, {31'b0, exp_q[0].is_branch});
            check_eq("illegal", {31'b0, bus.out_illegal}, {31'b0, exp_q[0].illegal});
        end
    endtask

    // Entered and left at a falling edge: check, drive, advance model, one clock
    task automatic step(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                        input logic f7, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        logic acc;
        alu_issue_t e;
        check_outputs();
        bus.in_valid    = v;
        bus.in_opcode   = opc;
        bus.in_funct3   = f3;
        bus.in_funct7b5 = f7;
        bus.in_rs1_data = a;
        bus.in_rs2_data = b;
        bus.in_imm      = imm;
        bus.in_pc       = pc;
        bus.out_ready   = ordy;
        flush           = fl;
        acc = v && (exp_q.size() < 2) && !fl;
        e = ref_decode(opc, f3, f7, a, b, imm, pc);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0 && ordy) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, ordy, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check_eq("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check_eq("rst_control", {28'b0, bus.out_control}, {28'b0, ALU_ADD});
        check_eq("rst_left", bus.out_left, 32'd0);
        check_eq("rst_right", bus.out_right, 32'd0);
        check_eq("rst_is_branch", {31'b0, bus.out_is_branch}, 32'd0);
        check_eq("rst_illegal", {31'b0, bus.out_illegal}, 32'd0);
        rst = 1'b0;
    endtask

    logic [6:0] opcs [9];
    logic [31:0] sra_res;

    initial begin
        opcs = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011,
                 7'b0100011, 7'b1101111, 7'b1100111, 7'b1100011};
        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_opcode = '0;
        bus.in_funct3 = '0;
        bus.in_funct7b5 = 1'b0;
        bus.in_rs1_data = '0;
        bus.in_rs2_data = '0;
        bus.in_imm = '0;
        bus.in_pc = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // SUB 5 - 7
        step(1'b1, 7'b0110011, 3'b000, 1'b1, 32'd5, 32'd7, 32'd0, 32'd0, 1'b1, 1'b0);
        check_eq("t1_valid", {31'b0, bus.out_valid}, 32'd1);
        check_eq("t1_control", {28'b0, bus.out_control}, {28'b0, ALU_SUB});
        check_eq("t1_left", bus.out_left, 32'd5);
        check_eq("t1_right", bus.out_right, 32'd7);

        // SRAI by 4
        step(1'b1, 7'b0010011, 3'b101, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 1'b1, 1'b0);
        check_eq("t2_control", {28'b0, bus.out_control}, {28'b0, ALU_SRA});
        check_eq("t2_right", bus.out_right, 32'd4);
        sra_res = $signed(bus.out_left) >>> bus.out_right[4:0];
        check_eq("t2_alu", sra_res, 32'hF800_0000);

        // BLT -1 < 1 is taken
        step(1'b1, 7'b1100011, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b1, 1'b0);
        check_eq("t3_control", {28'b0, bus.out_control}, {28'b0, B_BLT});
        check_eq("t3_is_branch", {31'b0, bus.out_is_branch}, 32'd1);
        check_eq("t3_taken", {31'b0, $signed(bus.out_left) < $signed(bus.out_right)}, 32'd1);
        idle(1'b1);

        // Stall: A to output, B to skid, then drain in order
        step(1'b1, 7'b0110011, 3'b000, 1'b0, 32'd11, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 7'b0110011, 3'b000, 1'b0, 32'd22, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0);
        idle(1'b0);
        check_eq("t4_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
        check_eq("t4_hold_a", bus.out_left, 32'd11);
        idle(1'b1);
        check_eq("t4_b_left", bus.out_left, 32'd22);
        check_eq("t4_in_ready_back", {31'b0, bus.in_ready}, 32'd1);
        idle(1'b1);
        check_eq("t4_drained", {31'b0, bus.out_valid}, 32'd0);

        // Flush with both entries full and C on input; then flush beats a legal accept
        step(1'b1, 7'b0110011, 3'b000, 1'b0, 32'd31, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 7'b0110011, 3'b000, 1'b0, 32'd32, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 7'b0110011, 3'b000, 1'b0, 32'd33, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        check_eq("t5_valid", {31'b0, bus.out_valid}, 32'd0);
        check_eq("t5_in_ready", {31'b0, bus.in_ready}, 32'd1);
        step(1'b1, 7'b0110011, 3'b000, 1'b0, 32'd34, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        check_eq("t5_flush_accept", {31'b0, bus.out_valid}, 32'd0);
        repeat (3) idle(1'b1);

        // Undecodable opcode
        step(1'b1, 7'b1111111, 3'b000, 1'b0, 32'd9, 32'd9, 32'd9, 32'd9, 1'b1, 1'b0);
        check_eq("t6_control", {28'b0, bus.out_control}, {28'b0, ALU_ADD});
        check_eq("t6_left", bus.out_left, 32'd0);
`ifdef ALU_ISSUE_ILLEGAL_EN
        check_eq("t6_illegal", {31'b0, bus.out_illegal}, 32'd1);
`else
        check_eq("t6_illegal", {31'b0, bus.out_illegal}, 32'd0);
`endif
        idle(1'b1);

        // Reset while stalled with both entries held
        step(1'b1, 7'b0010111, 3'b000, 1'b0, 32'd1, 32'd2, 32'd3, 32'h100, 1'b0, 1'b0);
        step(1'b1, 7'b1101111, 3'b000, 1'b0, 32'd1, 32'd2, 32'd3, 32'h104, 1'b0, 1'b0);
        do_reset();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(199) == 0) begin
                do_reset();
            end else begin
                logic [6:0] opc;
                int unsigned idx;
                idx = $urandom_range(9);
                opc = (idx == 9) ? 7'($urandom) : opcs[idx];
                step(($urandom_range(9) < 7), opc, 3'($urandom), 1'($urandom), $urandom,
                     $urandom, $urandom, {$urandom, 2'b00} >> 2 << 2,
                     ($urandom_range(9) < 6), ($urandom_range(19) == 0));
            end
        end
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
